req_gnt_arbiter: RTL and testbench

Round-robin request/grant arbiter producing the `gnt` handshake consumed by the req/gnt protocol checker stage. It serves up to `N_REQ` requesters. A grant issued for a request sampled with `cStart` high appears exactly `GNT_LATENCY` clocks later and holds stable until the requester drops `req` or a hold timeout fires. A mandatory idle cycle separates consecutive grants, so `gnt` never changes owner without passing through all-zero.

---
 rtl/req_gnt_arbiter.sv | 144 ++++++++++++++
 tb/tb_req_gnt_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_gnt_arbiter.sv
// req_gnt_arbiter: round-robin request/grant arbiter with fixed grant
// latency, forced release after MAX_HOLD cycles and one idle cycle between
// grants.
// Ports:
//   clk       - clock; every state update happens on posedge
//   rst       - synchronous active-high reset
//   cStart    - arbitration enable, only looked at while idle
//   req       - per-requester request levels
//   gnt       - registered one-hot grant (or all zero)
//   gnt_valid - registered OR of gnt
//   gnt_id    - registered index of the current or last winner
//   timeout   - one-clock pulse when a grant is forcibly released
module req_gnt_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GNT_LATENCY = 2,
    parameter int MAX_HOLD    = 8,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cStart,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_id,
    output logic             timeout
);

    localparam int LW = $clog2(GNT_LATENCY + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT,
        RELEASE
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]    ptr, ptr_nxt;
    logic [IW-1:0]    id_nxt;
    logic [LW-1:0]    lat, lat_nxt;
    logic [HW-1:0]    hold, hold_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic             valid_nxt;
    logic             to_nxt;

    logic [IW-1:0]    idx;
    logic [IW-1:0]    pick;
    logic             found;
    logic             at_limit;

    // First requester at or above the pointer, wrapping round to 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign at_limit = (hold == HW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lat       <= '0;
            hold      <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            lat       <= lat_nxt;
            hold      <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
            gnt_id    <= id_nxt;
            timeout   <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        id_nxt    = gnt_id;
        lat_nxt   = lat;
        hold_nxt  = hold;
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        to_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cStart && found) begin
                    id_nxt    = pick;
                    lat_nxt   = LW'(GNT_LATENCY - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!req[gnt_id]) begin
                    // Winner gave up before its grant: pointer untouched.
                    state_nxt = IDLE;
                end else if (lat == '0) begin
                    gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id;
                    valid_nxt = 1'b1;
                    hold_nxt  = HW'(1);
                    state_nxt = GRANT;
                end else begin
                    lat_nxt = lat - 1'b1;
                end
            end
            GRANT: begin
                if (!req[gnt_id] || at_limit) begin
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    // A voluntary drop wins over a coincident hold limit.
                    to_nxt    = req[gnt_id];
                    ptr_nxt   = (gnt_id == IW'(N_REQ - 1)) ?
                                '0 : gnt_id + 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    hold_nxt = hold + 1'b1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// tb_req_gnt_arbiter: scenario tasks for req_gnt_arbiter plus a random run
// compared against a cycle-counting reference model.
module tb_req_gnt_arbiter;

    localparam int N    = 4;
    localparam int LAT  = 2;
    localparam int MAXH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cStart = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: absolute edge numbers instead of counters.
    int m_cyc;
    int m_ptr;
    int m_pend;
    int m_due;
    int m_own;
    int m_start;
    int m_id;
    bit m_gap;
    bit m_to;

    req_gnt_arbiter #(
        .N_REQ(N),
        .GNT_LATENCY(LAT),
        .MAX_HOLD(MAXH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cStart(cStart),
        .req(req),
        .gnt(gnt),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        cStart = 1'b0;
        req    = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input bit cs,
                              input bit rs);
        bit hit;
        int i;
        m_cyc++;
        m_to = 1'b0;
        if (rs) begin
            m_ptr  = 0;
            m_pend = -1;
            m_own  = -1;
            m_gap  = 1'b0;
            m_id   = 0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_own >= 0) begin
            if (!r[m_own[1:0]] || (m_cyc - m_start) == MAXH) begin
                m_to  = r[m_own[1:0]];
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_gap = 1'b1;
            end
        end else if (m_pend >= 0) begin
            if (!r[m_pend[1:0]]) begin
                m_pend = -1;
            end else if (m_cyc == m_due) begin
                m_own   = m_pend;
                m_start = m_cyc;
                m_pend  = -1;
            end
        end else if (cs && r != '0) begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!hit && r[i[1:0]]) begin
                    hit    = 1'b1;
                    m_pend = i;
                    m_id   = i;
                    m_due  = m_cyc + LAT;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        cStart = 1'b1;
        req    = '1;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, gnt_id, timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b",
                     {gnt, gnt_valid, gnt_id, timeout}, 8'b0);
        end
        rst    = 1'b0;
        cStart = 1'b0;
        req    = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle_gnt: got %b want 0000", gnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        cStart = 1'b1;
        req    = 4'b0001;
        tick();
        cStart = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early: got %b want 0000", gnt);
        end
        for (int e = 3; e <= 5; e++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL single_gnt e%0d: got %b/%b want 0001/1",
                         e, gnt, gnt_valid);
            end
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, gnt_id, timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL single_drop: got %b want %b",
                     {gnt, gnt_valid, gnt_id, timeout}, 8'b0);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_after: got %b want 0000", gnt);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int w;
        logic [N-1:0] e;
        do_reset();
        cStart = 1'b1;
        req    = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = g % N;
            e = 4'(1 << w);
            n = 0;
            while (gnt == '0 && n < 12) begin
                tick();
                n++;
            end
            n_cmp++;
            if (gnt !== e) begin
                n_fail++;
                $display("FAIL rr_winner g%0d: got %b want %b after %0d",
                         g, gnt, e, n);
            end
            tick();
            n_cmp++;
            if (gnt !== e) begin
                n_fail++;
                $display("FAIL rr_hold g%0d: got %b want %b", g, gnt, e);
            end
            req[w] = 1'b0;
            tick();
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_gap g%0d: got %b want 0000", g, gnt);
            end
            req[w] = 1'b1;
        end
        cStart = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        cStart = 1'b1;
        req    = 4'b0100;
        tick();
        tick();
        for (int c = 0; c < MAXH; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold c%0d: got %b/%b want 0100/0",
                         c, gnt, timeout);
            end
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_pulse: got %b/%b want 0000/1", gnt, timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_end: got %b/%b want 0000/0", gnt, timeout);
        end
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_regrant_early: got %b want 0000", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL to_regrant: got %b id %0d want 0100 id 2",
                     gnt, gnt_id);
        end
        cStart = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        cStart = 1'b1;
        req    = 4'b0010;
        tick();
        cStart = 1'b0;
        req    = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_nognt c%0d: got %b want 0000", c, gnt);
            end
        end
        cStart = 1'b1;
        req    = 4'b0011;
        tick();
        cStart = 1'b0;
        n_cmp++;
        if (gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_ptr_id: got %0d want 0", gnt_id);
        end
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_next: got %b want 0001", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        cStart = 1'b1;
        req    = 4'b0001;
        tick();
        cStart = 1'b0;
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();
        cStart = 1'b1;
        req    = 4'b0010;
        tick();
        cStart = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL mr_pre: got %b want 0010", gnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({gnt, gnt_valid, gnt_id, timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL mr_clear: got %b want %b",
                     {gnt, gnt_valid, gnt_id, timeout}, 8'b0);
        end
        cStart = 1'b1;
        req    = 4'b0011;
        tick();
        cStart = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL mr_ptr0: got %b want 0001", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
        cStart = 1'b1;
        req    = 4'b0010;
        tick();
        cStart = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fail++;
            $display("FAIL mr_regrant: got %b id %0d want 0010 id 1",
                     gnt, gnt_id);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_cstart_gating();
        int bad;
        do_reset();
        req = 4'b1000;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt !== 4'b0000)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL cs_gate: got %0d granted cycles want 0", bad);
        end
        cStart = 1'b1;
        tick();
        cStart = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL cs_early: got %b want 0000", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL cs_grant: got %b want 1000", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [7:0]   exp;
        logic [N-1:0] r;
        m_cyc = 0;
        rst    = 1'b1;
        cStart = 1'b0;
        req    = '0;
        model_step(req, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(9) == 0)
                    r[b] = ~r[b];
            req    = r;
            cStart = 1'($urandom_range(1));
            rst    = ($urandom_range(199) == 0);
            model_step(req, cStart, rst);
            tick();
            exp[7:4] = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
            exp[3]   = (m_own >= 0);
            exp[2:1] = m_id[1:0];
            exp[0]   = m_to;
            n_cmp++;
            if ({gnt, gnt_valid, gnt_id, timeout} !== exp) begin
                n_fail++;
                $display("FAIL rand c%0d: got %b want %b", c,
                         {gnt, gnt_valid, gnt_id, timeout}, exp);
            end
        end
        rst    = 1'b0;
        cStart = 1'b0;
        req    = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_abort();
        test_mid_reset();
        test_cstart_gating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
